// File: rtl/turn_controller.sv
// Turn sequencer for a shared 3x3 board: enforces move order and cell legality,
// writes accepted moves, detects win/draw and holds off input for a lockout window.
module turn_controller #(
    parameter int FIRST_PLAYER   = 0,
    parameter int LOCKOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        new_game,
    input  logic        btn_p1,
    input  logic        btn_p2,
    input  logic [3:0]  sel_p1,
    input  logic [3:0]  sel_p2,
    output logic [17:0] board,
    output logic        turn,
    output logic        move_ok,
    output logic        move_err,
    output logic [1:0]  winner,
    output logic        game_over
);

    localparam int             CW         = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
    localparam logic [CW-1:0]  LOCK_LOAD  = CW'(LOCKOUT_CYCLES - 1);
    localparam logic           FIRST_TURN = (FIRST_PLAYER != 0);

    typedef enum logic [2:0] {
        S_WAIT,
        S_CHECK,
        S_WRITE,
        S_EVAL,
        S_LOCKOUT,
        S_OVER
    } state_t;

    state_t          state_reg, state_next;
    logic [17:0]     board_reg, board_next;
    logic            turn_reg, turn_next;
    logic            move_ok_reg, move_ok_next;
    logic            move_err_reg, move_err_next;
    logic [1:0]      winner_reg, winner_next;
    logic            game_over_reg, game_over_next;
    logic [3:0]      count_reg, count_next;
    logic [3:0]      sel_reg, sel_next;
    logic [CW-1:0]   lock_cnt_reg, lock_cnt_next;

    logic [1:0]      turn_code;
    logic            turn_btn;
    logic            other_btn;
    logic [3:0]      turn_sel;
    logic [15:0]     cell_blocked;
    logic [8:0]      cell_hit;
    logic [7:0]      line_win;
    logic [17:0]     board_written;

    assign turn_code = turn_reg ? 2'b10 : 2'b01;
    assign turn_btn  = turn_reg ? btn_p2 : btn_p1;
    assign other_btn = turn_reg ? btn_p1 : btn_p2;
    assign turn_sel  = turn_reg ? sel_p2 : sel_p1;

    // Indices 9..15 are treated as blocked so one lookup covers both range and occupancy.
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_blocked
            if (gi < 9) begin : g_cell
                assign cell_blocked[gi] = (board_reg[2*gi +: 2] != 2'b00);
            end else begin : g_range
                assign cell_blocked[gi] = 1'b1;
            end
        end
    endgenerate

    generate
        for (genvar gi = 0; gi < 9; gi++) begin : g_cells
            assign cell_hit[gi]            = (board_reg[2*gi +: 2] == turn_code);
            assign board_written[2*gi +: 2] = (sel_reg == 4'(gi)) ? turn_code
                                                                  : board_reg[2*gi +: 2];
        end
    endgenerate

    // Lines 0..2 are rows, 3..5 columns, 6..7 diagonals; checked for the mover's code.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_lines
            assign line_win[gi]     = cell_hit[3*gi] & cell_hit[3*gi+1] & cell_hit[3*gi+2];
            assign line_win[3 + gi] = cell_hit[gi] & cell_hit[gi+3] & cell_hit[gi+6];
        end
    endgenerate
    assign line_win[6] = cell_hit[0] & cell_hit[4] & cell_hit[8];
    assign line_win[7] = cell_hit[2] & cell_hit[4] & cell_hit[6];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= S_WAIT;
            board_reg     <= '0;
            turn_reg      <= FIRST_TURN;
            move_ok_reg   <= 1'b0;
            move_err_reg  <= 1'b0;
            winner_reg    <= 2'b00;
            game_over_reg <= 1'b0;
            count_reg     <= '0;
            sel_reg       <= '0;
            lock_cnt_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            board_reg     <= board_next;
            turn_reg      <= turn_next;
            move_ok_reg   <= move_ok_next;
            move_err_reg  <= move_err_next;
            winner_reg    <= winner_next;
            game_over_reg <= game_over_next;
            count_reg     <= count_next;
            sel_reg       <= sel_next;
            lock_cnt_reg  <= lock_cnt_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        board_next     = board_reg;
        turn_next      = turn_reg;
        move_ok_next   = 1'b0;
        move_err_next  = 1'b0;
        winner_next    = winner_reg;
        game_over_next = game_over_reg;
        count_next     = count_reg;
        sel_next       = sel_reg;
        lock_cnt_next  = lock_cnt_reg;

        case (state_reg)
            S_WAIT: begin
                if (turn_btn) begin
                    sel_next   = turn_sel;
                    state_next = S_CHECK;
                end else if (other_btn) begin
                    move_err_next = 1'b1;
                end
            end
            S_CHECK: begin
                if (cell_blocked[sel_reg]) begin
                    move_err_next = 1'b1;
                    state_next    = S_WAIT;
                end else begin
                    state_next = S_WRITE;
                end
            end
            S_WRITE: begin
                board_next   = board_written;
                move_ok_next = 1'b1;
                count_next   = count_reg + 4'd1;
                state_next   = S_EVAL;
            end
            S_EVAL: begin
                // A line completed on the ninth move is a win, not a draw.
                if (|line_win) begin
                    winner_next    = turn_code;
                    game_over_next = 1'b1;
                    state_next     = S_OVER;
                end else if (count_reg == 4'd9) begin
                    winner_next    = 2'b11;
                    game_over_next = 1'b1;
                    state_next     = S_OVER;
                end else begin
                    turn_next     = ~turn_reg;
                    lock_cnt_next = LOCK_LOAD;
                    state_next    = S_LOCKOUT;
                end
            end
            S_LOCKOUT: begin
                if (lock_cnt_reg == '0) begin
                    state_next = S_WAIT;
                end else begin
                    lock_cnt_next = lock_cnt_reg - 1'b1;
                end
            end
            S_OVER: begin
                state_next = S_OVER;
            end
            default: begin
                state_next = S_WAIT;
            end
        endcase

        if (new_game) begin
            state_next     = S_WAIT;
            board_next     = '0;
            turn_next      = FIRST_TURN;
            move_ok_next   = 1'b0;
            move_err_next  = 1'b0;
            winner_next    = 2'b00;
            game_over_next = 1'b0;
            count_next     = '0;
            sel_next       = '0;
            lock_cnt_next  = '0;
        end
    end

    assign board     = board_reg;
    assign turn      = turn_reg;
    assign move_ok   = move_ok_reg;
    assign move_err  = move_err_reg;
    assign winner    = winner_reg;
    assign game_over = game_over_reg;

    a_pulse_exclusive: assert property (@(posedge clk) disable iff (reset)
        !(move_ok_reg && move_err_reg));

    a_over_has_winner: assert property (@(posedge clk) disable iff (reset)
        game_over_reg |-> (winner_reg != 2'b00));

endmodule

// File: tb/tb_turn_controller.sv
// Bench for turn_controller: table of presses with expected response kind and winner,
// a scoreboard queue for pulse checks, and hand sequences for lockout/new_game/reset.
module tb_turn_controller;

    localparam int LOCK = 4;
    localparam int K_NONE = 0, K_OK = 1, K_TURN = 2, K_CELL = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        new_game;
    logic        btn_p1, btn_p2;
    logic [3:0]  sel_p1, sel_p2;
    logic [17:0] board;
    logic        turn, move_ok, move_err, game_over;
    logic [1:0]  winner;

    turn_controller #(.FIRST_PLAYER(0), .LOCKOUT_CYCLES(LOCK)) dut (
        .clk(clk), .reset(reset), .new_game(new_game),
        .btn_p1(btn_p1), .btn_p2(btn_p2), .sel_p1(sel_p1), .sel_p2(sel_p2),
        .board(board), .turn(turn), .move_ok(move_ok), .move_err(move_err),
        .winner(winner), .game_over(game_over)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit ng;
        int who;
        int s1;
        int s2;
        int kind;
        int win;
    } vec_t;

    typedef struct {
        int kind;
        int lat;
    } exp_t;

    vec_t        vecs[$];
    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    int          ok_cnt = 0;
    int          err_cnt = 0;
    logic [17:0] model_board;
    logic        model_turn;

    always @(negedge clk) begin
        if (move_ok)  ok_cnt++;
        if (move_err) err_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    function automatic vec_t mk(bit ng, int who, int s1, int s2, int kind, int win);
        vec_t v;
        v.ng = ng; v.who = who; v.s1 = s1; v.s2 = s2; v.kind = kind; v.win = win;
        return v;
    endfunction

    task automatic check_eq(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, req);
        end
    endtask

    task automatic model_reset();
        model_board = '0;
        model_turn  = 1'b0;
    endtask

    task automatic press(input int who, input logic [3:0] s1, input logic [3:0] s2);
        @(posedge clk); #1;
        sel_p1 = s1;
        sel_p2 = s2;
        btn_p1 = (who == 1 || who == 3);
        btn_p2 = (who == 2 || who == 3);
        @(posedge clk); #1;
        btn_p1 = 1'b0;
        btn_p2 = 1'b0;
    endtask

    task automatic do_new_game();
        @(posedge clk); #1;
        new_game = 1'b1;
        @(posedge clk); #1;
        new_game = 1'b0;
    endtask

    task automatic apply_vec(input vec_t v, input int idx);
        exp_t        e;
        int          hi, first, got_ok;
        logic [3:0]  sel;
        if (v.ng) begin
            do_new_game();
            model_reset();
        end
        e.kind = v.kind;
        e.lat  = (v.kind == K_OK) ? 3 : (v.kind == K_TURN) ? 1 : (v.kind == K_CELL) ? 2 : 0;
        sb.push_back(e);
        press(v.who, 4'(v.s1), 4'(v.s2));
        hi = 0; first = 0; got_ok = 0;
        for (int lat = 1; lat <= 6; lat++) begin
            @(negedge clk);
            if (move_ok || move_err) begin
                hi++;
                if (first == 0) begin
                    first  = lat;
                    got_ok = int'(move_ok);
                end
            end
        end
        e = sb.pop_front();
        if (e.kind == K_NONE) begin
            check_eq($sformatf("v%0d pulses", idx), hi, 0);
        end else begin
            check_eq($sformatf("v%0d ok_vs_err", idx), got_ok, (e.kind == K_OK) ? 1 : 0);
            check_eq($sformatf("v%0d latency", idx), first, e.lat);
            check_eq($sformatf("v%0d width", idx), hi, 1);
        end
        if (e.kind == K_OK) begin
            sel = model_turn ? 4'(v.s2) : 4'(v.s1);
            model_board[2*sel +: 2] = model_turn ? 2'b10 : 2'b01;
            if (v.win == 0) model_turn = ~model_turn;
        end
        repeat (LOCK + 2) @(posedge clk);
        #1;
        $display("vec %0d who=%0d s1=%0d s2=%0d board=%05h turn=%0d winner=%0d over=%0d",
                 idx, v.who, v.s1, v.s2, board, turn, winner, game_over);
        check_eq($sformatf("v%0d board", idx), int'(board), int'(model_board));
        check_eq($sformatf("v%0d turn", idx), int'(turn), int'(model_turn));
        check_eq($sformatf("v%0d winner", idx), int'(winner), v.win);
        check_eq($sformatf("v%0d game_over", idx), int'(game_over), (v.win != 0) ? 1 : 0);
    endtask

    initial begin
        int ok0, err0;
        // Opening game: turn/cell errors, simultaneous presses
        vecs.push_back(mk(0, 2, 0, 0, K_TURN, 0));
        vecs.push_back(mk(0, 1, 4, 0, K_OK,   0));
        vecs.push_back(mk(0, 2, 0, 4, K_CELL, 0));
        vecs.push_back(mk(0, 2, 0, 9, K_CELL, 0));
        vecs.push_back(mk(0, 1, 0, 0, K_TURN, 0));
        vecs.push_back(mk(0, 3, 1, 0, K_OK,   0));
        // P1 wins on the top row, later presses ignored
        vecs.push_back(mk(1, 1, 0, 0, K_OK,   0));
        vecs.push_back(mk(0, 2, 0, 3, K_OK,   0));
        vecs.push_back(mk(0, 1, 1, 0, K_OK,   0));
        vecs.push_back(mk(0, 2, 0, 4, K_OK,   0));
        vecs.push_back(mk(0, 1, 2, 0, K_OK,   1));
        vecs.push_back(mk(0, 2, 0, 5, K_NONE, 1));
        vecs.push_back(mk(0, 1, 6, 0, K_NONE, 1));
        // Nine moves, no line: draw
        vecs.push_back(mk(1, 1, 0, 0, K_OK, 0));
        vecs.push_back(mk(0, 2, 0, 1, K_OK, 0));
        vecs.push_back(mk(0, 1, 2, 0, K_OK, 0));
        vecs.push_back(mk(0, 2, 0, 4, K_OK, 0));
        vecs.push_back(mk(0, 1, 3, 0, K_OK, 0));
        vecs.push_back(mk(0, 2, 0, 5, K_OK, 0));
        vecs.push_back(mk(0, 1, 7, 0, K_OK, 0));
        vecs.push_back(mk(0, 2, 0, 6, K_OK, 0));
        vecs.push_back(mk(0, 1, 8, 0, K_OK, 3));
        // Ninth move completes column 0: win beats draw
        vecs.push_back(mk(1, 1, 0, 0, K_OK, 0));
        vecs.push_back(mk(0, 2, 0, 1, K_OK, 0));
        vecs.push_back(mk(0, 1, 2, 0, K_OK, 0));
        vecs.push_back(mk(0, 2, 0, 4, K_OK, 0));
        vecs.push_back(mk(0, 1, 3, 0, K_OK, 0));
        vecs.push_back(mk(0, 2, 0, 5, K_OK, 0));
        vecs.push_back(mk(0, 1, 7, 0, K_OK, 0));
        vecs.push_back(mk(0, 2, 0, 8, K_OK, 0));
        vecs.push_back(mk(0, 1, 6, 0, K_OK, 1));
        // P2 wins on the middle row
        vecs.push_back(mk(1, 1, 0, 0, K_OK, 0));
        vecs.push_back(mk(0, 2, 0, 3, K_OK, 0));
        vecs.push_back(mk(0, 1, 1, 0, K_OK, 0));
        vecs.push_back(mk(0, 2, 0, 4, K_OK, 0));
        vecs.push_back(mk(0, 1, 8, 0, K_OK, 0));
        vecs.push_back(mk(0, 2, 0, 5, K_OK, 2));

        reset = 1'b1; new_game = 1'b0;
        btn_p1 = 1'b0; btn_p2 = 1'b0; sel_p1 = '0; sel_p2 = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_eq("reset board", int'(board), 0);
        check_eq("reset turn", int'(turn), 0);
        check_eq("reset winner", int'(winner), 0);
        check_eq("reset game_over", int'(game_over), 0);
        check_eq("reset move_ok", int'(move_ok), 0);
        check_eq("reset move_err", int'(move_err), 0);

        for (int i = 0; i < vecs.size(); i++) apply_vec(vecs[i], i);

        // Presses landing inside the lockout window are dropped silently
        do_new_game();
        model_reset();
        ok0 = ok_cnt; err0 = err_cnt;
        press(1, 4'd4, 4'd0);
        repeat (2) @(posedge clk);
        press(2, 4'd0, 4'd0);
        press(1, 4'd1, 4'd0);
        repeat (6) @(posedge clk);
        #1;
        $display("lockout drop: board=%05h turn=%0d oks=%0d errs=%0d",
                 board, turn, ok_cnt - ok0, err_cnt - err0);
        check_eq("lockout oks", ok_cnt - ok0, 1);
        check_eq("lockout errs", err_cnt - err0, 0);
        check_eq("lockout board", int'(board), 32'h100);
        check_eq("lockout turn", int'(turn), 1);

        // new_game while locked out clears everything back to WAIT
        ok0 = ok_cnt;
        press(2, 4'd0, 4'd0);
        repeat (3) @(posedge clk);
        do_new_game();
        $display("new_game mid-lockout: board=%05h turn=%0d winner=%0d over=%0d",
                 board, turn, winner, game_over);
        check_eq("ng board", int'(board), 0);
        check_eq("ng turn", int'(turn), 0);
        check_eq("ng winner", int'(winner), 0);
        check_eq("ng game_over", int'(game_over), 0);
        repeat (6) @(posedge clk);
        #1;
        check_eq("ng oks", ok_cnt - ok0, 1);
        model_reset();
        apply_vec(mk(0, 1, 8, 0, K_OK, 0), 100);

        // Asynchronous reset while the P2 move sits in CHECK
        ok0 = ok_cnt;
        press(2, 4'd0, 4'd2);
        #2 reset = 1'b1;
        #1;
        $display("async reset mid-check: board=%05h turn=%0d", board, turn);
        check_eq("areset board", int'(board), 0);
        check_eq("areset turn", int'(turn), 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check_eq("areset oks", ok_cnt - ok0, 0);
        check_eq("areset board later", int'(board), 0);
        model_reset();
        apply_vec(mk(0, 1, 5, 0, K_OK, 0), 101);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
